// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg: shared FSM state encoding and ALU opcodes
package poly_eval_pkg;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;
endpackage

// File: rtl/poly_alu.sv
// poly_alu: shared multiply/add unit with width-overflow detection
module poly_alu
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] y,
  output logic             ov
);
  logic [2*WIDTH-1:0] w_ae, w_be, w_p;
  logic [WIDTH:0]     w_s;
  // full-precision product and sum, then truncate and flag loss of information
  always_comb begin
    w_ae = {{WIDTH{SIGNED & a[WIDTH-1]}}, a};
    w_be = {{WIDTH{SIGNED & b[WIDTH-1]}}, b};
    w_p  = w_ae * w_be;
    w_s  = {1'b0, a} + {1'b0, b};
    y    = op == OP_MUL ? w_p[WIDTH-1:0] : w_s[WIDTH-1:0];
    ov   = op == OP_MUL
         ? (SIGNED ? !(&w_p[2*WIDTH-1:WIDTH-1] || ~|w_p[2*WIDTH-1:WIDTH-1]) : |w_p[2*WIDTH-1:WIDTH])
         : (SIGNED ? (a[WIDTH-1] == b[WIDTH-1]) && (w_s[WIDTH-1] != a[WIDTH-1]) : w_s[WIDTH]);
  end
endmodule

// File: rtl/poly_eval.sv
// poly_eval: Horner-rule polynomial evaluator with start/done handshake
module poly_eval
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEGREE = 2,
  parameter bit SIGNED = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          x,
  input  logic [(DEGREE+1)*WIDTH-1:0] coef,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          result,
  output logic                      ovf
);
  localparam int KW = DEGREE > 0 ? $clog2(DEGREE + 1) : 1;
  state_t                     r_state, w_next;
  logic [WIDTH-1:0]           r_x, r_s, r_h, r_result, w_ck, w_a, w_b, w_y;
  logic [DEGREE:0][WIDTH-1:0] r_c;
  logic [KW-1:0]              r_k;
  logic                       r_ovi, r_ovf, w_op, w_ov, w_accept;

  poly_alu #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_alu (
    .a (w_a),
    .b (w_b),
    .op(w_op),
    .y (w_y),
    .ov(w_ov)
  );

  assign result = r_result;
  assign ovf    = r_ovf;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next state, status outputs and ALU operand steering
  always_comb begin
    w_accept = start && (r_state == IDLE || r_state == DONE);
    w_next   = w_accept ? (DEGREE > 0 ? MUL : DONE)
             : r_state == MUL ? ADD
             : r_state == ADD ? (r_k == '0 ? DONE : MUL)
             : r_state == DONE ? IDLE : r_state;
    busy     = r_state == MUL || r_state == ADD;
    done     = r_state == DONE;
    w_ck     = r_c[r_k];
    w_op     = r_state == MUL ? OP_MUL : OP_ADD;
    w_a      = r_state == MUL ? r_s : r_h;
    w_b      = r_state == MUL ? r_x : w_ck;
  end

  // operand capture and Horner accumulation; overflow sticks for the whole evaluation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_c      <= '0;
      r_s      <= '0;
      r_h      <= '0;
      r_k      <= '0;
      r_ovi    <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_x   <= x;
      r_c   <= coef;
      r_s   <= coef[DEGREE*WIDTH +: WIDTH];
      r_k   <= KW'(DEGREE > 0 ? DEGREE - 1 : 0);
      r_ovi <= 1'b0;
      if (DEGREE == 0) begin
        r_result <= coef[WIDTH-1:0];
        r_ovf    <= 1'b0;
      end
    end else if (r_state == MUL) begin
      r_h   <= w_y;
      r_ovi <= r_ovi | w_ov;
    end else if (r_state == ADD) begin
      r_s   <= w_y;
      r_ovi <= r_ovi | w_ov;
      if (r_k == '0) begin
        r_result <= w_y;
        r_ovf    <= r_ovi | w_ov;
      end else begin
        r_k <= r_k - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_poly_eval.sv
// tb_poly_eval: directed vectors against a Horner-step arithmetic model
module tb_poly_eval;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [15:0] x0 = '0, x2 = '0, cf2 = '0, cf1 = '0;
  logic [7:0]  x1 = '0;
  logic [47:0] cf0 = '0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  logic [15:0] res0, res2;
  logic [7:0]  res1;
  int          checks = 0, errors = 0, sel = 0;
  logic        cur_busy, cur_done, cur_ovf;
  logic [15:0] cur_res;

  always #5 clk = ~clk;

  poly_eval #(.WIDTH(16), .DEGREE(2), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .start(s0), .x(x0), .coef(cf0),
    .busy(busy0), .done(done0), .result(res0), .ovf(ovf0));
  poly_eval #(.WIDTH(8), .DEGREE(1), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .x(x1), .coef(cf1),
    .busy(busy1), .done(done1), .result(res1), .ovf(ovf1));
  poly_eval #(.WIDTH(16), .DEGREE(0), .SIGNED(0)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .x(x2), .coef(cf2),
    .busy(busy2), .done(done2), .result(res2), .ovf(ovf2));

  always_comb begin
    cur_busy = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
    cur_done = sel == 0 ? done0 : sel == 1 ? done1 : done2;
    cur_ovf  = sel == 0 ? ovf0 : sel == 1 ? ovf1 : ovf2;
    cur_res  = sel == 0 ? res0 : sel == 1 ? {8'h00, res1} : res2;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(longint v, longint m, bit sgn);
    return (sgn && v >= m / 2) ? v - m : v;
  endfunction

  function automatic bit fits(longint v, longint m, bit sgn);
    return sgn ? (v >= -m / 2 && v < m / 2) : (v >= 0 && v < m);
  endfunction

  // exact Horner evaluation: each step must fit the word, result kept mod 2^w
  function automatic logic [16:0] eval(int w, int deg, bit sgn, longint xv,
                                       longint c0, longint c1, longint c2);
    longint m = longint'(1) << w;
    longint cs[3];
    longint s, p, xu;
    bit ov = 1'b0;
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    xu = xv & (m - 1);
    s  = cs[deg] & (m - 1);
    for (int i = deg - 1; i >= 0; i--) begin
      p  = sx(s, m, sgn) * sx(xu, m, sgn);
      ov = ov | !fits(p, m, sgn);
      s  = p & (m - 1);
      p  = sx(s, m, sgn) + sx(cs[i] & (m - 1), m, sgn);
      ov = ov | !fits(p, m, sgn);
      s  = p & (m - 1);
    end
    return {ov, 16'(s)};
  endfunction

  // timeline model of dut0: evaluation takes 2*DEGREE cycles, then a one-cycle done
  int          cnt = 0;
  logic        e_done = 1'b0, e_ovf = 1'b0, p_ovf = 1'b0;
  logic [15:0] e_res = '0, p_res = '0;
  always @(posedge clk) begin
    if (rst) begin
      cnt = 0; e_done = 1'b0; e_res = '0; e_ovf = 1'b0;
    end else if (cnt > 0) begin
      cnt--;
      e_done = cnt == 0;
      if (cnt == 0) begin
        e_res = p_res; e_ovf = p_ovf;
      end
    end else begin
      e_done = 1'b0;
      if (s0) begin
        {p_ovf, p_res} = eval(16, 2, 1'b0, longint'(x0), longint'(cf0[15:0]),
                              longint'(cf0[31:16]), longint'(cf0[47:32]));
        cnt = 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy0", 64'(busy0), 64'(cnt > 0));
    chk("done0", 64'(done0), 64'(e_done));
    chk("busy_done_excl", 64'(busy0 & done0), 64'(0));
    chk("result0", 64'(res0), 64'(e_res));
    chk("ovf0", 64'(ovf0), 64'(e_ovf));
  end

  task automatic run(int d, logic [15:0] xv, logic [47:0] cf, int elat,
                     logic [15:0] eres, logic eovf, string nm);
    int t = 0, bc = 0;
    sel = d;
    if (d == 0) begin x0 = xv; cf0 = cf; s0 = 1'b1; end
    else if (d == 1) begin x1 = xv[7:0]; cf1 = cf[15:0]; s1 = 1'b1; end
    else begin x2 = xv; cf2 = cf[15:0]; s2 = 1'b1; end
    @(negedge clk);
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    bc = int'(cur_busy);
    while (!cur_done && t < 20) begin
      @(negedge clk);
      t++;
      bc += int'(cur_busy);
    end
    chk({nm, "_latency"}, 64'(t), 64'(elat));
    chk({nm, "_busycycles"}, 64'(bc), 64'(elat));
    chk({nm, "_result"}, 64'(cur_res), 64'(eres));
    chk({nm, "_ovf"}, 64'(cur_ovf), 64'(eovf));
    @(negedge clk);
  endtask

  initial begin
    int first, second, n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(0, 16'd5, {16'd2, 16'd3, 16'd4}, 4, 16'd69, 1'b0, "basic");
    run(0, 16'h0100, {16'd1, 16'd0, 16'd0}, 4, 16'h0000, 1'b1, "mulovf");
    run(0, 16'd3, {16'd7, 16'hFFFF, 16'd2}, 4, 16'd62, 1'b1, "addovf");
    // start pulsed again while busy must be ignored
    x0 = 16'd5; cf0 = {16'd2, 16'd3, 16'd4}; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    @(negedge clk); x0 = 16'd9; s0 = 1'b1;
    @(negedge clk); s0 = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); n += int'(done0); end
    chk("repulse_dones", 64'(n), 64'(1));
    // start held through DONE: back-to-back evaluations
    x0 = 16'd5; cf0 = {16'd2, 16'd3, 16'd4}; s0 = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 && first < 0) first = i;
      else if (done0 && second < 0) second = i;
    end
    s0 = 1'b0;
    chk("held_first", 64'(first), 64'(4));
    chk("held_gap", 64'(second - first), 64'(5));
    repeat (8) @(negedge clk);
    run(0, 16'd5, {16'd2, 16'd3, 16'd4}, 4, 16'd69, 1'b0, "again");
    // reset in the middle of an evaluation aborts it silently
    s0 = 1'b1;
    @(negedge clk); s0 = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 64'(busy0), 64'(0));
    chk("abort_done", 64'(done0), 64'(0));
    chk("abort_result", 64'(res0), 64'(0));
    chk("abort_ovf", 64'(ovf0), 64'(0));
    n = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); n += int'(done0); end
    chk("abort_nodone", 64'(n), 64'(0));
    run(1, 16'd4, {32'd0, 8'hFD, 8'h0A}, 2, 16'h00FE, 1'b0, "signed_ok");
    run(1, 16'd100, {32'd0, 8'hFD, 8'h0A}, 2, 16'h00DE, 1'b1, "signed_ovf");
    run(2, 16'd7, {32'd0, 16'h1234}, 0, 16'h1234, 1'b0, "deg0");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/poly_eval.md
# poly_eval

Parametrised polynomial evaluator, y = c[N]·x^N + … + c[1]·x + c[0], computed by Horner's rule. An internal control FSM sequences a multiply/add datapath over an arbitrary degree and data width, with a start/done handshake and overflow reporting. It is the next-generation operative+control pair for the polynomial datapath: fixed three coefficients and external mux/load strobes give way to self-sequenced operation.

## Interface
- WIDTH, 16, data width of x, coefficients and result
- DEGREE, 2, polynomial degree N (≥0); DEGREE+1 coefficients
- SIGNED, 0, 1 = operands two's complement (affects overflow detection only)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request evaluation; sampled only when accepting
- x  in  WIDTH  evaluation point, captured on accepted start
- coef  in  (DEGREE+1)*WIDTH  coefficients, c[i] = coef[i*WIDTH +: WIDTH], captured on accepted start
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  y modulo 2^WIDTH, held until next completion
- ovf  out  1  sticky overflow for the last evaluation, valid with done

## Operation
- Internal regs: RX (x), RC (coefficient bank), S (accumulator), H (product), k (index, $clog2(DEGREE+1) bits, min 1).
- States: IDLE, MUL, ADD, DONE.
- Accept: start=1 while in IDLE or DONE. Capture RX←x, RC←coef, S←c[N], k←N−1, ovf_int←0. Next state: MUL if DEGREE>0, else DONE with result←c[0].
- MUL: H←(S·RX) truncated to WIDTH; ovf_int set if full-precision product does not fit WIDTH (unsigned, or signed when SIGNED=1). → ADD.
- ADD: S←H + c[k] truncated; overflow by the same rule (unsigned carry-out or signed overflow). If k==0: result←new S, ovf←ovf_int | this-step overflow, → DONE; else k←k−1, → MUL.
- DONE: done=1 for exactly this cycle; → IDLE unless start accepted (back-to-back).
- start in MUL/ADD ignored; no queueing. x/coef changes after acceptance have no effect.
- Arithmetic: all intermediate values truncated to WIDTH each step; result equals the exact polynomial mod 2^WIDTH.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, ovf=0, internal regs 0.
- rst overrides everything on any edge, including mid-evaluation; no done is produced for an aborted evaluation.
- busy = 1 in MUL and ADD only; 0 in IDLE and DONE.
- Latency: start accepted at edge E → done=1 in the cycle after edge E+2·DEGREE; result/ovf update on that same edge.
- Throughput: one evaluation per 2·DEGREE+1 cycles with start held or re-asserted during DONE.
- done and busy are never high together.

## Structure
- Package poly_eval_pkg: state enum (IDLE, MUL, ADD, DONE), ALU op constants (OP_MUL, OP_ADD).
- Sub-module poly_alu: combinational, WIDTH/SIGNED params, inputs a, b, op; outputs y (WIDTH) and ov. Single instance shared by MUL and ADD.
- Top: FSM + registers + coefficient select mux (c[k]).

## Test plan
- WIDTH=16, DEGREE=2, c={2,3,4} (c2..c0), x=5, start pulse → done in cycle after E+4, result=69, ovf=0, busy high 4 cycles.
- Same config, x=0x0100, c={1,0,0} → result=0x0000, ovf=1.
- SIGNED=1, WIDTH=8, DEGREE=1, c1=−3, c0=10, x=4 → result=0xFE (−2), ovf=0; x=100 → ovf=1.
- DEGREE=0, c0=0x1234, start → done in cycle after E, result=0x1234, busy never high.
- start re-pulsed while busy → ignored, single done; start held through DONE → second evaluation accepted, next done 2·DEGREE+1 cycles later.
- rst asserted mid-MUL → next cycle busy=0, done=0, result=0, ovf=0; no done pulse follows.
